// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   fsm_t        controller state encoding (RUN / MEM_WAIT / MEM_ERR)
//   FWD_*        forwarding mux select encodings for the Execute operands
//   DEF_REG_W    default register-address width
package hazard_pkg;

  localparam int DEF_REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } fsm_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: combinational operand-forwarding selection.
//   rs1_e/rs2_e        Execute source registers
//   rs1_d/rs2_d        Decode source registers (branch compare operands)
//   rd_m/rd_w          Memory / Writeback destination registers
//   reg_write_m/_w     Memory / Writeback stage writes a register
//   mem_to_reg_m       Memory stage holds a load (data not ready for Decode)
//   fwd_a_e/fwd_b_e    Execute operand mux selects (FWD_RF / FWD_M / FWD_W)
//   fwd_a_d/fwd_b_d    Decode compare operand taken from Memory stage
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_to_reg_m,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             fwd_a_d,
  output logic             fwd_b_d
);

  // x0 is hardwired zero, so a write to it is never a forwarding source.
  logic m_ok, w_ok;
  assign m_ok = reg_write_m && (rd_m != '0);
  assign w_ok = reg_write_w && (rd_w != '0);

  // Memory stage is younger than Writeback, so it wins.
  always_comb begin
    fwd_a_e = FWD_RF;
    if (m_ok && (rd_m == rs1_e))      fwd_a_e = FWD_M;
    else if (w_ok && (rd_w == rs1_e)) fwd_a_e = FWD_W;

    fwd_b_e = FWD_RF;
    if (m_ok && (rd_m == rs2_e))      fwd_b_e = FWD_M;
    else if (w_ok && (rd_w == rs2_e)) fwd_b_e = FWD_W;
  end

  assign fwd_a_d = m_ok && !mem_to_reg_m && (rd_m == rs1_d);
  assign fwd_b_d = m_ok && !mem_to_reg_m && (rd_m == rs2_d);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward controller with data-memory wait
// handling, memory-timeout trap and saturating stall-cycle counter.
//   clk, rst                 clock; synchronous active-low reset
//   Rs*/Rd*/RegWrite*/MemToReg*  pipeline register-use information
//   BranchD, PCSrcD          branch in Decode and its raw taken flag
//   MemReqM, DMemReadyM      data-memory request and completion
//   Stall*/Flush*/RedirectF  pipeline register controls and PC redirect
//   Forward*                 forwarding mux selects
//   MemErr                   sticky memory timeout
//   StallCount               saturating count of cycles with StallF=1
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal flow; load-use / branch hazards stall Fetch+Decode
// MEM_WAIT | data memory busy; whole pipe frozen, timer counts wait cycles
// MEM_ERR  | memory never answered; pipe frozen until reset
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int          REG_W       = DEF_REG_W,
  parameter int          CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             MemToRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MemReqM,
  input  logic             DMemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             RedirectF,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(MEM_TIMEOUT - 1);

  fsm_t             state;
  logic [TMR_W-1:0] timer;
  logic [1:0]       fae, fbe;
  logic             fad, fbd;
  logic             lw_stall, br_stall, hz, wait_now;

  fwd_unit #(.REG_W(REG_W)) u_fwd (
    .rs1_e        (Rs1E),
    .rs2_e        (Rs2E),
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .rd_m         (RdM),
    .rd_w         (RdW),
    .reg_write_m  (RegWriteM),
    .reg_write_w  (RegWriteW),
    .mem_to_reg_m (MemToRegM),
    .fwd_a_e      (fae),
    .fwd_b_e      (fbe),
    .fwd_a_d      (fad),
    .fwd_b_d      (fbd)
  );

  assign lw_stall = MemToRegE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign br_stall = BranchD &&
                    ((RegWriteE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D))) ||
                     (MemToRegM && (RdM != '0) && ((RdM == Rs1D) || (RdM == Rs2D))));
  assign hz = lw_stall || br_stall;

  // A miss seen in RUN freezes the pipe in the same cycle it is detected.
  assign wait_now = (state != RUN) || (MemReqM && !DMemReadyM);

  assign MemErr = (state == MEM_ERR);

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    RedirectF = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fae;
      ForwardBE = fbe;
      ForwardAD = fad;
      ForwardBD = fbd;
      if (wait_now) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF    = hz;
        StallD    = hz;
        FlushE    = hz;
        RedirectF = PCSrcD && !hz;
        FlushD    = PCSrcD && !hz;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      timer      <= '0;
      StallCount <= '0;
    end else begin
      if (StallF && (StallCount != '1)) StallCount <= StallCount + 1'b1;
      case (state)
        RUN: begin
          if (MemReqM && !DMemReadyM) begin
            timer <= TMR_W'(1);
            state <= (MEM_TIMEOUT == 1) ? MEM_ERR : MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (DMemReadyM) begin
            state <= RUN;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
            if (timer == TMO_LAST) state <= MEM_ERR;
          end
        end
        MEM_ERR: state <= MEM_ERR;
        default: begin
          state <= RUN;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic       BranchD, PCSrcD, MemReqM, DMemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, RedirectF;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, MemErr;
  logic [3:0] StallCount;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .CNT_W(4), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .MemReqM(MemReqM), .DMemReadyM(DMemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .RedirectF(RedirectF),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MemErr(MemErr), .StallCount(StallCount)
  );

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemToRegE = 0; MemToRegM = 0;
    BranchD = 0; PCSrcD = 0; MemReqM = 0; DMemReadyM = 0;
  endtask

  // Leaves the bench just after a negedge with reset released and inputs idle.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    PCSrcD = 1; MemReqM = 1; RegWriteM = 1; RdM = 3; Rs1E = 3;
    #1;
    total++; if (StallF !== 1'b0) $display("FAIL rst_stallf got %b exp 0", StallF); else passed++;
    total++; if (StallE !== 1'b0) $display("FAIL rst_stalle got %b exp 0", StallE); else passed++;
    total++; if ({FlushD, FlushE, FlushW} !== 3'b111) $display("FAIL rst_flush got %b exp 111", {FlushD, FlushE, FlushW}); else passed++;
    total++; if (RedirectF !== 1'b0) $display("FAIL rst_redirect got %b exp 0", RedirectF); else passed++;
    total++; if (ForwardAE !== 2'b00) $display("FAIL rst_fwdae got %b exp 00", ForwardAE); else passed++;
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #1;
    total++; if (StallCount !== 4'd0) $display("FAIL rst_count got %0d exp 0", StallCount); else passed++;
    total++; if (MemErr !== 1'b0) $display("FAIL rst_memerr got %b exp 0", MemErr); else passed++;
    total++; if (StallF !== 1'b0) $display("FAIL rst_run_stallf got %b exp 0", StallF); else passed++;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    do_reset();
    MemToRegE = 1; RegWriteE = 1; RdE = 5; Rs1D = 5;
    #1;
    total++; if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL lu_stall got %b exp 111", {StallF, StallD, FlushE}); else passed++;
    total++; if ({StallE, StallM, FlushW} !== 3'b000) $display("FAIL lu_back got %b exp 000", {StallE, StallM, FlushW}); else passed++;
    @(negedge clk);
    clear_inputs();
    RegWriteM = 1; MemToRegM = 1; RdM = 5; Rs1E = 5; MemReqM = 1; DMemReadyM = 1;
    #1;
    total++; if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL lu_release got %b exp 000", {StallF, StallD, FlushE}); else passed++;
    total++; if (ForwardAE !== 2'b10) $display("FAIL lu_fwdae got %b exp 10", ForwardAE); else passed++;
    total++; if (StallCount !== 4'd1) $display("FAIL lu_count got %0d exp 1", StallCount); else passed++;
    @(negedge clk);
    // Load to x0 is never a hazard.
    clear_inputs();
    MemToRegE = 1; RdE = 0; Rs1D = 0;
    #1;
    total++; if (StallF !== 1'b0) $display("FAIL lu_x0 got %b exp 0", StallF); else passed++;
    @(negedge clk);
  endtask

  task automatic test_forward();
    clear_inputs();
    RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 3; Rs1E = 3; Rs2E = 3;
    #1;
    total++; if (ForwardAE !== 2'b10) $display("FAIL fwd_m_pri got %b exp 10", ForwardAE); else passed++;
    total++; if (ForwardBE !== 2'b10) $display("FAIL fwd_be_m got %b exp 10", ForwardBE); else passed++;
    RdM = 0;
    #1;
    total++; if (ForwardAE !== 2'b01) $display("FAIL fwd_w got %b exp 01", ForwardAE); else passed++;
    RdW = 0;
    #1;
    total++; if (ForwardAE !== 2'b00) $display("FAIL fwd_rf got %b exp 00", ForwardAE); else passed++;
    RdW = 9; Rs2E = 9; RegWriteW = 0;
    #1;
    total++; if (ForwardBE !== 2'b00) $display("FAIL fwd_nowrite got %b exp 00", ForwardBE); else passed++;
    clear_inputs();
    RegWriteM = 1; RdM = 4; Rs1D = 4; Rs2D = 6;
    #1;
    total++; if ({ForwardAD, ForwardBD} !== 2'b10) $display("FAIL fwd_ad got %b exp 10", {ForwardAD, ForwardBD}); else passed++;
    MemToRegM = 1;
    #1;
    total++; if (ForwardAD !== 1'b0) $display("FAIL fwd_ad_load got %b exp 0", ForwardAD); else passed++;
    @(negedge clk);
  endtask

  task automatic test_branch();
    do_reset();
    BranchD = 1; PCSrcD = 1; RegWriteE = 1; RdE = 7; Rs2D = 7; Rs1D = 1;
    #1;
    total++; if ({RedirectF, FlushD} !== 2'b00) $display("FAIL br_hold got %b exp 00", {RedirectF, FlushD}); else passed++;
    total++; if ({StallD, FlushE} !== 2'b11) $display("FAIL br_stall got %b exp 11", {StallD, FlushE}); else passed++;
    @(negedge clk);
    RdE = 3;
    #1;
    total++; if ({RedirectF, FlushD, StallD} !== 3'b110) $display("FAIL br_go got %b exp 110", {RedirectF, FlushD, StallD}); else passed++;
    @(negedge clk);
    // Load in Memory feeding the branch also stalls.
    clear_inputs();
    BranchD = 1; PCSrcD = 1; MemToRegM = 1; RegWriteM = 1; RdM = 2; Rs1D = 2;
    #1;
    total++; if ({StallD, RedirectF} !== 2'b10) $display("FAIL br_ldm got %b exp 10", {StallD, RedirectF}); else passed++;
    @(negedge clk);
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReqM = 1; DMemReadyM = 0; PCSrcD = 1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) DMemReadyM = 1;
      if (i == 3) begin MemToRegE = 1; RdE = 5; Rs1D = 5; end
      #1;
      total++; if ({StallF, StallD, StallE, StallM, FlushW} !== 5'b11111) $display("FAIL mw_stall%0d got %b exp 11111", i, {StallF, StallD, StallE, StallM, FlushW}); else passed++;
      total++; if ({FlushD, FlushE, RedirectF} !== 3'b000) $display("FAIL mw_noflush%0d got %b exp 000", i, {FlushD, FlushE, RedirectF}); else passed++;
      @(negedge clk);
    end
    clear_inputs();
    PCSrcD = 1;
    #1;
    total++; if ({StallF, StallE, FlushW} !== 3'b000) $display("FAIL mw_run got %b exp 000", {StallF, StallE, FlushW}); else passed++;
    total++; if (RedirectF !== 1'b1) $display("FAIL mw_redirect got %b exp 1", RedirectF); else passed++;
    total++; if (StallCount !== 4'd5) $display("FAIL mw_count got %0d exp 5", StallCount); else passed++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    MemReqM = 1; DMemReadyM = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      total++; if ({MemErr, StallF} !== 2'b01) $display("FAIL to_wait%0d got %b exp 01", i, {MemErr, StallF}); else passed++;
      @(negedge clk);
    end
    for (int i = 9; i <= 12; i++) begin
      if (i == 11) DMemReadyM = 1;
      #1;
      total++; if ({MemErr, StallF, FlushW} !== 3'b111) $display("FAIL to_err%0d got %b exp 111", i, {MemErr, StallF, FlushW}); else passed++;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    PCSrcD = 1;
    #1;
    total++; if (MemErr !== 1'b0) $display("FAIL to_clr_err got %b exp 0", MemErr); else passed++;
    total++; if (StallCount !== 4'd0) $display("FAIL to_clr_count got %0d exp 0", StallCount); else passed++;
    total++; if ({StallF, RedirectF} !== 2'b01) $display("FAIL to_run got %b exp 01", {StallF, RedirectF}); else passed++;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    do_reset();
    MemReqM = 1; DMemReadyM = 0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (i == 15) begin
        total++; if (StallCount !== 4'd14) $display("FAIL sat_14 got %0d exp 14", StallCount); else passed++;
      end
      if (i == 16) begin
        total++; if (StallCount !== 4'd15) $display("FAIL sat_15 got %0d exp 15", StallCount); else passed++;
      end
      @(negedge clk);
    end
    #1;
    total++; if (StallCount !== 4'd15) $display("FAIL sat_hold got %0d exp 15", StallCount); else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage pipeline.
- Drives the stall and flush controls of every pipeline register (IF/ID StallD, PCSrcD-flush path, ID/EX, EX/MEM, MEM/WB) and the forwarding muxes.
- Detects load-use and branch-in-decode hazards, and freezes the pipe while the multi-cycle data memory is busy.
- Traps a memory that never answers with a timeout error state, and keeps a saturating stall-cycle counter.

Parameters:
- REG_W, 5, register address width
- CNT_W, 16, width of stall-cycle counter
- MEM_TIMEOUT, 255, max consecutive wait cycles before MEM_ERR (≥1, < 2^CNT_W)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- Rs1D, Rs2D  in  REG_W  source regs of instruction in Decode
- Rs1E, Rs2E, RdE  in  REG_W  source/dest regs in Execute
- RdM, RdW  in  REG_W  dest regs in Memory / Writeback
- RegWriteE, RegWriteM, RegWriteW  in  1  stage writes a register
- MemToRegE, MemToRegM  in  1  instruction in E / M is a load
- BranchD  in  1  Decode holds a branch/jump resolved in D
- PCSrcD  in  1  raw branch-taken from Decode
- MemReqM  in  1  Memory stage accesses data memory this cycle
- DMemReadyM  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM
- FlushD, FlushE, FlushW  out  1  bubble into IF-ID / ID-EX / MEM-WB
- RedirectF  out  1  gated PC redirect (PC mux select)
- ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W
- ForwardAD, ForwardBD  out  1  branch compare operand from M
- MemErr  out  1  sticky memory-timeout error
- StallCount  out  CNT_W  cycles with StallF=1, saturating

Behaviour:
- Register x0 is never a hazard source and never forwarded: every match requires Rd != 0.
- Forwarding, combinational, all states:
  - ForwardAE = 10 if RegWriteM & RdM==Rs1E; else 01 if RegWriteW & RdW==Rs1E; else 00. M takes priority over W. ForwardBE is the same on Rs2E.
  - ForwardAD = RegWriteM & RdM==Rs1D & ~MemToRegM. ForwardBD is the same on Rs2D.
- Hazard terms:
  - lwStall = MemToRegE & (RdE==Rs1D | RdE==Rs2D)
  - brStall = BranchD & ((RegWriteE & RdE matches Rs1D/Rs2D) | (MemToRegM & RdM matches Rs1D/Rs2D))
  - hz = lwStall | brStall
- FSM states RUN, MEM_WAIT, MEM_ERR. Registered state; all outputs are combinational from state and inputs.
- RUN:
  - If MemReqM & ~DMemReadyM, behave as MEM_WAIT this cycle and go to MEM_WAIT with timer=1.
  - Otherwise: StallF=StallD=hz; FlushE=hz; StallE=StallM=FlushW=0.
  - RedirectF = FlushD = PCSrcD & ~hz.
- MEM_WAIT:
  - StallF=StallD=StallE=StallM=1; FlushW=1; FlushD=FlushE=RedirectF=0. Hazard terms are ignored; memory wait has top priority.
  - Each cycle with DMemReadyM=0, timer increments. On timer==MEM_TIMEOUT, go to MEM_ERR.
  - On DMemReadyM=1: this cycle still stalls. Next cycle go to RUN, timer cleared.
- MEM_ERR: same outputs as MEM_WAIT, plus MemErr=1. Exited only by reset.
- StallCount increments every cycle StallF=1 and saturates at all-ones.
- Reset (rst=0 at a clk edge, in any state including mid-MEM_WAIT):
  - state=RUN, timer=0, MemErr=0, StallCount=0.
  - While rst=0, outputs are forced to: all Stall*=0, FlushD=FlushE=FlushW=1, RedirectF=0, Forward*=0.

Decomposition:
- Shared package hazard_pkg:
  - enum fsm_t {RUN, MEM_WAIT, MEM_ERR}
  - fwd encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - REG_W default
- One natural sub-module, fwd_unit: purely combinational ForwardAE/BE/AD/BD logic, instantiated once.

Test Plan:
- lw x5 in E (MemToRegE=1, RdE=5) with Rs1D=5 -> StallF=StallD=FlushE=1 for exactly that cycle; next cycle, with the load now in M, ForwardAE=10 for Rs1E=5.
- RegWriteM=1, RdM=3 and RegWriteW=1, RdW=3 with Rs1E=3 -> ForwardAE=10. Set RdM=0 -> ForwardAE=01. RdW=0 too -> 00.
- BranchD=1, PCSrcD=1, RegWriteE=1, RdE=7=Rs2D -> RedirectF=0, StallD=1. Next cycle RdE≠7 -> RedirectF=FlushD=1.
- MemReqM=1, DMemReadyM=0 for 4 cycles then 1 -> all stalls and FlushW high for 5 cycles, back to RUN on cycle 6; StallCount=5.
- MEM_TIMEOUT=8, DMemReadyM held 0 -> MemErr=1 after 8 wait cycles and stays 1. Drive rst=0 one cycle -> MemErr=0, StallCount=0, state RUN.
- Hold StallF=1 (memory wait) with CNT_W=4 for 20 cycles -> StallCount saturates at 15.
